audio_capture: RTL and testbench

AUDIO_CAPTURE -- requirements
Module: audio_capture

---
 rtl/audio_pkg.sv | 31 +++
 rtl/audio_mix_quant.sv | 34 +++
 rtl/audio_capture.sv | 159 +++++++++++++++
 tb/tb_audio_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path.
// Holds the RAM address / sample widths, the capture FSM state type and a
// helper that turns a signed stored sample into a saturated 5-bit magnitude.
package audio_pkg;

  localparam int unsigned ADDR_W   = 18;
  localparam int unsigned SAMPLE_W = 6;
  localparam int unsigned AUDIO_W  = 32;
  localparam int unsigned DECIM_W  = 11;
  localparam int unsigned PEAK_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FINISH  = 2'd2
  } cap_state_t;

  // |s| for a 6-bit two's-complement sample; -32 has no positive twin so it clamps to 31
  function automatic logic [PEAK_W-1:0] sample_mag(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = SAMPLE_W'(-s);
    if (s == -SAMPLE_W'(32)) begin
      sample_mag = PEAK_W'(31);
    end else if (s < 0) begin
      sample_mag = PEAK_W'(neg);
    end else begin
      sample_mag = PEAK_W'(s);
    end
  endfunction

endpackage

// File: rtl/audio_mix_quant.sv
// Stereo-to-mono mix and quantiser.
// Ports:
//   CLOCK_50  clock
//   reset     synchronous active-high reset, clears q
//   load      capture the current quantised mix into q
//   left/right  signed 32-bit ADC samples (show-ahead, valid this cycle)
//   q         registered 6-bit sample (one cycle after load)
//   quant_c   combinational 6-bit sample of the current inputs
module audio_mix_quant
  import audio_pkg::*;
(
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       load,
  input  logic signed [AUDIO_W-1:0]  left,
  input  logic signed [AUDIO_W-1:0]  right,
  output logic        [SAMPLE_W-1:0] q,
  output logic        [SAMPLE_W-1:0] quant_c
);

  // Halving each channel before the add keeps the 32-bit sum in range;
  // the top six bits are taken by plain truncation.
  assign quant_c = SAMPLE_W'(((left >>> 1) + (right >>> 1)) >>> (AUDIO_W - SAMPLE_W));

  // Output register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= quant_c;
    end
  end

endmodule

// File: rtl/audio_capture.sv
// Audio capture engine: drains the Audio_Controller ADC FIFO, mixes L/R to a
// 6-bit mono sample, decimates, and writes DEPTH samples into RAM starting at
// BASE_ADDR.
// Optional feature macro: PEAK_DETECT_EN (tracks max |sample| in peak; when
// undefined peak is tied to 0).
// Ports:
//   CLOCK_50, reset            clock, synchronous active-high reset
//   start, stop                one-cycle control pulses
//   audio_in_available         ADC FIFO non-empty
//   left/right_channel_audio_in  signed ADC samples (show-ahead)
//   read_audio_in              FIFO pop strobe (mirrors audio_in_available)
//   wr_en, wr_addr, wr_data    RAM write port
//   busy, done                 capture in progress / completion pulse
//   sample_count, peak         status of current or last capture
module audio_capture
  import audio_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 18'd0,
  parameter logic [ADDR_W-1:0]  DEPTH     = 18'd16396,
  parameter logic [DECIM_W-1:0] DECIM     = 11'd1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       audio_in_available,
  input  logic signed [AUDIO_W-1:0]  left_channel_audio_in,
  input  logic signed [AUDIO_W-1:0]  right_channel_audio_in,
  output logic                       read_audio_in,
  output logic                       wr_en,
  output logic        [ADDR_W-1:0]   wr_addr,
  output logic        [SAMPLE_W-1:0] wr_data,
  output logic                       busy,
  output logic                       done,
  output logic        [ADDR_W-1:0]   sample_count,
  output logic        [PEAK_W-1:0]   peak
);

  localparam logic [DECIM_W-1:0] DEC_LAST = DECIM - DECIM_W'(1);

  cap_state_t          state, state_nxt;
  logic [DECIM_W-1:0]  dec_cnt, dec_nxt;
  logic [ADDR_W-1:0]   cnt_nxt, addr_nxt;
  logic                wr_en_nxt, busy_nxt, done_nxt;
  logic                keep_c, clear_c;
  logic [SAMPLE_W-1:0] quant_c;

  // The FIFO is popped whenever it has data, regardless of state
  assign read_audio_in = audio_in_available;

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    dec_nxt   = dec_cnt;
    cnt_nxt   = sample_count;
    addr_nxt  = wr_addr;
    wr_en_nxt = 1'b0;
    keep_c    = 1'b0;
    clear_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_CAPTURE;
          dec_nxt   = '0;
          cnt_nxt   = '0;
          clear_c   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // stop wins over everything, including a sample on the same cycle
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (sample_count == DEPTH) begin
          state_nxt = ST_FINISH;
        end else if (audio_in_available) begin
          if (dec_cnt == DEC_LAST) begin
            keep_c    = 1'b1;
            dec_nxt   = '0;
            wr_en_nxt = 1'b1;
            addr_nxt  = BASE_ADDR + sample_count;
            cnt_nxt   = sample_count + ADDR_W'(1);
          end else begin
            dec_nxt = dec_cnt + DECIM_W'(1);
          end
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt == ST_CAPTURE);
    done_nxt = (state_nxt == ST_FINISH);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= ST_IDLE;
      dec_cnt      <= '0;
      sample_count <= '0;
      wr_addr      <= BASE_ADDR;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      dec_cnt      <= dec_nxt;
      sample_count <= cnt_nxt;
      wr_addr      <= addr_nxt;
      wr_en        <= wr_en_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Mix and quantise; registers the kept sample alongside wr_en
  audio_mix_quant u_mix_quant (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (keep_c),
    .left     (left_channel_audio_in),
    .right    (right_channel_audio_in),
    .q        (wr_data),
    .quant_c  (quant_c)
  );

`ifdef PEAK_DETECT_EN
  logic [PEAK_W-1:0] mag_c, peak_nxt;

  // Peak updates on the same edge the write is launched
  assign mag_c = sample_mag(quant_c);

  always_comb begin
    peak_nxt = peak;
    if (clear_c) begin
      peak_nxt = '0;
    end else if (keep_c && (mag_c > peak)) begin
      peak_nxt = mag_c;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      peak <= '0;
    end else begin
      peak <= peak_nxt;
    end
  end
`else
  logic unused_peak_inputs;

  assign unused_peak_inputs = ^{quant_c, clear_c};
  assign peak = '0;
`endif

endmodule

// File: tb/tb_audio_capture.sv
// Bench for audio_capture: two instances (DECIM=1 base 0, DECIM=3 base 100,
// both DEPTH=4) driven in lockstep against a sample-level reference model,
// plus literal expectations for the directed scenarios.
module tb_audio_capture;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_in = '0;
  logic [31:0] right_in = '0;

  logic [1:0]  rd_v, wr_en_v, busy_v, done_v;
  logic [17:0] wr_addr_v [2];
  logic [5:0]  wr_data_v [2];
  logic [17:0] cnt_v [2];
  logic [4:0]  peak_v [2];

  audio_capture #(.BASE_ADDR(18'd0), .DEPTH(18'd4), .DECIM(11'd1)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
    .read_audio_in(rd_v[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]),
    .wr_data(wr_data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sample_count(cnt_v[0]), .peak(peak_v[0])
  );

  audio_capture #(.BASE_ADDR(18'd100), .DEPTH(18'd4), .DECIM(11'd3)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
    .read_audio_in(rd_v[1]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]),
    .wr_data(wr_data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sample_count(cnt_v[1]), .peak(peak_v[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, i, act, exp);
    end
  endfunction

  // ---------------- reference model (one record per instance) ----------------
  typedef struct {
    bit cap;
    bit fin;
    int cnt;
    int acc;
    int peak;
    bit wr_en;
    int addr;
    int data;
  } mdl_t;

  mdl_t m [2];
  int depth_p [2] = '{4, 4};
  int decim_p [2] = '{1, 3};
  int base_p  [2] = '{0, 100};

  function automatic int quant(input logic [31:0] l, input logic [31:0] r);
    logic signed [31:0] mx;
    logic [5:0] q;
    mx = ($signed(l) >>> 1) + ($signed(r) >>> 1);
    q = mx[31:26];
    return int'(q);
  endfunction

  function automatic int mag6(input int d);
    int s;
    s = (d >= 32) ? d - 64 : d;
    if (s < 0) s = -s;
    return (s > 31) ? 31 : s;
  endfunction

  // Expected outputs after the coming clock edge, from the inputs just applied
  task automatic model_step(input int i);
    if (reset) begin
      m[i].cap = 0; m[i].fin = 0; m[i].cnt = 0; m[i].acc = 0; m[i].peak = 0;
      m[i].wr_en = 0; m[i].addr = base_p[i]; m[i].data = 0;
      return;
    end
    m[i].wr_en = 0;
    if (m[i].cap) begin
      if (stop) begin
        m[i].cap = 0;
      end else if (m[i].cnt == depth_p[i]) begin
        m[i].cap = 0;
        m[i].fin = 1;
      end else if (audio_in_available) begin
        m[i].acc++;
        if (m[i].acc % decim_p[i] == 0) begin
          m[i].wr_en = 1;
          m[i].addr  = base_p[i] + m[i].cnt;
          m[i].data  = quant(left_in, right_in);
          m[i].cnt++;
`ifdef PEAK_DETECT_EN
          if (mag6(m[i].data) > m[i].peak) m[i].peak = mag6(m[i].data);
`endif
        end
      end
    end else if (m[i].fin) begin
      m[i].fin = 0;
    end else if (start && !stop) begin
      m[i].cap = 1; m[i].cnt = 0; m[i].acc = 0; m[i].peak = 0;
    end
  endtask

  // ---------------- write / done recorder ----------------
  typedef struct { int cyc; int addr; int data; } wr_rec_t;
  wr_rec_t wq0[$];
  wr_rec_t wq1[$];
  int dcnt [2] = '{0, 0};
  int dcyc [2] = '{0, 0};

  // Compare every output of both instances against the model
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("read_audio_in", i, rd_v[i], audio_in_available);
        chk("wr_en", i, wr_en_v[i], m[i].wr_en);
        chk("wr_addr", i, wr_addr_v[i], m[i].addr);
        chk("wr_data", i, wr_data_v[i], m[i].data);
        chk("busy", i, busy_v[i], m[i].cap);
        chk("done", i, done_v[i], m[i].fin);
        chk("sample_count", i, cnt_v[i], m[i].cnt);
        chk("peak", i, peak_v[i], m[i].peak);
      end
      if (wr_en_v[0]) wq0.push_back('{cyc, int'(wr_addr_v[0]), int'(wr_data_v[0])});
      if (wr_en_v[1]) wq1.push_back('{cyc, int'(wr_addr_v[1]), int'(wr_data_v[1])});
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) begin
          dcnt[i]++;
          dcyc[i] = cyc;
        end
      end
    end
  end

  // Apply one cycle of inputs and advance the model past the next edge
  task automatic drv(input bit rs, input bit s, input bit sp, input bit av,
                     input logic [31:0] l, input logic [31:0] r);
    @(negedge CLOCK_50);
    #1;
    reset = rs; start = s; stop = sp; audio_in_available = av;
    left_in = l; right_in = r;
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic smp(input logic [31:0] l, input logic [31:0] r);
    drv(0, 0, 0, 1, l, r);
  endtask

  int exp_pk;
  int d0_before;

  initial begin
    // reset
    drv(1, 0, 0, 0, 32'h0, 32'h0);
    drv(1, 0, 0, 0, 32'h0, 32'h0);
    idle(1);
    chk("rst_busy", 0, busy_v[0], 0);
    chk("rst_addr", 1, wr_addr_v[1], 100);

    // basic capture: 4 samples of 0x4000_0000 -> data 0x10 at 0..3, then done
    wq0.delete(); wq1.delete(); dcnt[0] = 0;
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) smp(32'h4000_0000, 32'h4000_0000);
    idle(3);
    chk("t1_nwr", 0, wq0.size(), 4);
    foreach (wq0[k]) begin
      chk("t1_addr", 0, wq0[k].addr, k);
      chk("t1_data", 0, wq0[k].data, 6'h10);
    end
    if (wq0.size() == 4) chk("t1_done_lat", 0, dcyc[0], wq0[3].cyc + 1);
    chk("t1_ndone", 0, dcnt[0], 1);
    chk("t1_count", 0, cnt_v[0], 4);
    chk("t1_nwr", 1, wq1.size(), 1);
    drv(0, 0, 1, 0, 32'h0, 32'h0);
    idle(1);

    // decimation by 3: nine samples k<<26 give writes of 3, 6, 9
    wq0.delete(); wq1.delete();
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      smp(32'(k) << 26, 32'(k) << 26);
      if (k == 5) idle(1);
    end
    idle(2);
    chk("t2_nwr", 1, wq1.size(), 3);
    foreach (wq1[k]) begin
      chk("t2_addr", 1, wq1[k].addr, 100 + k);
      chk("t2_data", 1, wq1[k].data, 3 * (k + 1));
    end
    chk("t2_nwr", 0, wq0.size(), 4);
    drv(0, 0, 1, 0, 32'h0, 32'h0);
    idle(1);

    // stop after two writes; the sample on the stop cycle is dropped
    wq0.delete(); wq1.delete(); d0_before = dcnt[0];
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    smp(32'h1C00_0000, 32'h1C00_0000);
    smp(32'h2400_0000, 32'h2400_0000);
    drv(0, 0, 1, 1, 32'h2C00_0000, 32'h2C00_0000);
    chk("t3_pending_wr", 0, wr_en_v[0], 1);
    smp(32'h0400_0000, 32'h0400_0000);
    chk("t3_busy", 0, busy_v[0], 0);
    smp(32'h0400_0000, 32'h0400_0000);
    smp(32'h0400_0000, 32'h0400_0000);
    idle(1);
    chk("t3_nwr", 0, wq0.size(), 2);
    chk("t3_count", 0, cnt_v[0], 2);
    chk("t3_ndone", 0, dcnt[0], d0_before);

    // peak: stored samples 0x05, 0x20 (-32), 0x03
    wq0.delete();
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    smp(32'h1400_0000, 32'h1400_0000);
    smp(32'h8000_0000, 32'h8000_0000);
    smp(32'h0C00_0000, 32'h0C00_0000);
    idle(1);
`ifdef PEAK_DETECT_EN
    exp_pk = 31;
`else
    exp_pk = 0;
`endif
    chk("t4_peak", 0, peak_v[0], exp_pk);
    chk("t4_nwr", 0, wq0.size(), 3);
    if (wq0.size() == 3) begin
      chk("t4_d0", 0, wq0[0].data, 6'h05);
      chk("t4_d1", 0, wq0[1].data, 6'h20);
      chk("t4_d2", 0, wq0[2].data, 6'h03);
    end
    drv(0, 0, 1, 0, 32'h0, 32'h0);
    idle(1);

    // samples while idle are popped but never written
    wq0.delete(); wq1.delete();
    for (int k = 0; k < 6; k++) drv(0, 0, 0, k[0], $urandom, $urandom);
    drv(0, 1, 1, 1, 32'h4000_0000, 32'h0);
    smp(32'h4000_0000, 32'h0);
    idle(1);
    chk("t5_nwr", 0, wq0.size(), 0);
    chk("t5_nwr", 1, wq1.size(), 0);

    // reset mid-capture with a write in flight
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    smp(32'h7C00_0000, 32'h7C00_0000);
    drv(1, 0, 0, 1, 32'h7C00_0000, 32'h7C00_0000);
    chk("t6_pending_wr", 0, wr_en_v[0], 1);
    idle(1);
    chk("t6_wr_en", 0, wr_en_v[0], 0);
    chk("t6_busy", 0, busy_v[0], 0);
    chk("t6_count", 0, cnt_v[0], 0);
    chk("t6_addr", 0, wr_addr_v[0], 0);
    chk("t6_data", 0, wr_data_v[0], 0);
    chk("t6_peak", 0, peak_v[0], 0);

    // recovery: a full capture with random samples and gaps
    drv(0, 1, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) drv(0, 0, 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
